// File: rtl/interval_arbiter_if.sv
// Handshake bundle between the interval arbiter (slave) and its client/requester side (master).
interface interval_arbiter_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] q;

  modport master (output req, len0, len1, input gnt, done, busy, q);
  modport slave  (input req, len0, len1, output gnt, done, busy, q);
endinterface

// File: rtl/interval_arbiter.sv
// Round-robin share of one 4-bit interval counter between two requesters; grant 1 cycle after req, done L cycles later.
// No backpressure: a requester holds req for the interval, and dropping it aborts without a done pulse.
module interval_arbiter (
  input  logic             clk,
  input  logic             rst,
  interval_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic       pick;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    // On a tie the requester that did not go last wins; a lone request always wins.
    pick    = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = COUNT;
          owner_d = pick;
          last_d  = pick;
          len_d   = pick ? bus.len1 : bus.len0;
          cnt_d   = 4'd0;
          gnt_d   = pick ? 2'b10 : 2'b01;
        end
      end
      COUNT: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          cnt_d   = 4'd0;
        end else if (cnt_q == len_q - 4'd1) begin
          // len 0 wraps to a terminal count of 15, giving a 16-cycle interval.
          state_d = DONE;
          gnt_d   = 2'b00;
          done_d  = owner_q ? 2'b10 : 2'b01;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.q    = cnt_q;

endmodule

// File: tb/tb_interval_arbiter.sv
// Directed scenarios followed by sticky random requests, all checked cycle by cycle against an interval-level model.
module tb_interval_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Model: which requester holds the timer, how far into its interval, pending done pulse.
  int m_owner;
  int m_done;
  int m_last;
  int m_len;
  int m_elapsed;

  interval_arbiter_if bus ();

  interval_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_done    = -1;
    m_last    = 1;
    m_len     = 0;
    m_elapsed = 0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    int w;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner   = -1;
        m_elapsed = 0;
      end else if (m_elapsed + 1 == m_len) begin
        m_done    = m_owner;
        m_owner   = -1;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (r != 2'b00) begin
      if (r == 2'b11) w = 1 - m_last;
      else            w = r[1] ? 1 : 0;
      m_owner   = w;
      m_last    = w;
      m_len     = (w == 1) ? int'(l1) : int'(l0);
      if (m_len == 0) m_len = 16;
      m_elapsed = 0;
    end
  endtask

  task automatic check_all();
    logic [1:0] eg;
    logic [1:0] ed;
    eg = 2'b00;
    ed = 2'b00;
    if (m_owner == 0) eg = 2'b01;
    if (m_owner == 1) eg = 2'b10;
    if (m_done == 0)  ed = 2'b01;
    if (m_done == 1)  ed = 2'b10;
    chk("gnt",  32'(bus.gnt),  32'(eg));
    chk("done", 32'(bus.done), 32'(ed));
    chk("busy", 32'(bus.busy), 32'((m_owner >= 0) || (m_done >= 0)));
    chk("q",    32'(bus.q),    32'(m_elapsed));
  endtask

  task automatic cyc(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    bus.req  = r;
    bus.len0 = l0;
    bus.len1 = l1;
    @(posedge clk);
    model_step(r, l0, l1);
    #1;
    check_all();
  endtask

  // Pulse rst between edges; outputs must clear before any clock edge arrives.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [1:0] r;
    logic [3:0] l0;
    logic [3:0] l1;

    rst      = 1'b1;
    bus.req  = 2'b00;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single interval of 3 on requester 0.
    for (int i = 0; i < 6; i++) cyc(2'b01, 4'd3, 4'd0);
    for (int i = 0; i < 2; i++) cyc(2'b00, 4'd3, 4'd0);

    // Alternation with both requesting, then reset mid-stream with req held.
    for (int i = 0; i < 24; i++) cyc(2'b11, 4'd2, 4'd5);
    for (int i = 0; i < 3; i++) cyc(2'b11, 4'd2, 4'd5);
    async_reset();
    for (int i = 0; i < 4; i++) cyc(2'b11, 4'd2, 4'd5);
    for (int i = 0; i < 8; i++) cyc(2'b00, 4'd2, 4'd5);

    // Length 0 encodes a 16-cycle interval.
    for (int i = 0; i < 20; i++) cyc(2'b10, 4'd1, 4'd0);
    for (int i = 0; i < 2; i++) cyc(2'b00, 4'd1, 4'd0);

    // Abort requester 1 at q == 2, then a tie must go to requester 0.
    for (int i = 0; i < 20 && !(m_owner == 1 && m_elapsed == 2); i++) cyc(2'b10, 4'd3, 4'd8);
    chk("abort_at_q2", 32'(bus.q), 32'd2);
    cyc(2'b00, 4'd3, 4'd8);
    for (int i = 0; i < 6; i++) cyc(2'b11, 4'd3, 4'd8);
    for (int i = 0; i < 12; i++) cyc(2'b00, 4'd3, 4'd8);

    // Length changes mid-interval are ignored.
    cyc(2'b01, 4'd4, 4'd0);
    cyc(2'b01, 4'd4, 4'd0);
    for (int i = 0; i < 6; i++) cyc(2'b01, 4'd9, 4'd0);
    for (int i = 0; i < 2; i++) cyc(2'b00, 4'd9, 4'd0);

    // Random sticky requests and lengths with occasional asynchronous reset.
    r  = 2'b00;
    l0 = 4'd1;
    l1 = 4'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) l0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) l1 = 4'($urandom_range(0, 15));
      cyc(r, l0, l1);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
